// File: rtl/pal_dma_pkg.sv
// Shared definitions for the palette DMA writer: FSM states, plane selects, sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pal_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } pal_dma_state_t;

    localparam logic [1:0] PLANE_R = 2'b00;
    localparam logic [1:0] PLANE_G = 2'b01;
    localparam logic [1:0] PLANE_B = 2'b10;

    localparam int PAL_ENTRIES = 256;
    localparam int PAL_WRITES  = 768;

    // Palette chip CPU address: A11:A10 plane, A9 = 0, A8:A1 entry, A0 = 0.
    function automatic logic [19:0] pal_addr(input logic [1:0] plane, input logic [7:0] idx);
        return {8'd0, plane, 1'b0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/pal_dma_addr_gen.sv
// Upload position counter {plane, entry} with source and palette address formation.
// Latency: addresses are combinational from the registered counter and base.
// Backpressure: advances only on i_advance; i_load restarts at R entry 0.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_load latches i_base and
//        clears the counter; i_advance steps the counter; o_src_addr, o_pal_a, o_last.
module pal_dma_addr_gen #(
    parameter int SRC_AW  = 20,
    parameter int ENTRIES = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [SRC_AW-1:0] i_base,
    input  logic              i_advance,
    output logic [SRC_AW-1:0] o_src_addr,
    output logic [19:0]       o_pal_a,
    output logic              o_last
);
    import pal_dma_pkg::*;

    logic [SRC_AW-1:0] r_base;
    // Bits [9:8] are the plane, [7:0] the entry, so the value is also c*256+i.
    logic [9:0]        r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_base <= i_base;
            r_cnt  <= '0;
        end else if (i_advance) begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // Modulo-2^SRC_AW sum: the source window may wrap past the top of memory.
    assign o_src_addr = r_base + SRC_AW'(r_cnt);
    assign o_pal_a    = pal_addr(r_cnt[9:8], r_cnt[7:0]);
    assign o_last     = (r_cnt[9:8] == PLANE_B) && (r_cnt[7:0] == 8'(ENTRIES - 1));

endmodule

// File: rtl/pal_dma_writer.sv
// Bulk uploader of the R/G/B palette planes (3 x 256 words) into the M72 palette chip.
// Latency: one write per (3 + GAP_CYCLES) cycles with zero-wait SRC_ACK; DONE after write 768.
// Backpressure: SRC_RD held with stable SRC_ADDR until SRC_ACK; optional VBLANK stall before WRITE.
// Ports: CLK_32M/RESET_N clock and async active-low reset; START/SRC_BASE launch an upload;
//        BUSY/DONE status; SRC_ADDR/SRC_RD/SRC_ACK/SRC_DATA work-RAM read port;
//        PAL_G/PAL_MWR/PAL_A/PAL_DIN palette chip write port; VBLANK gate input.
// Build option: define PAL_DMA_VBLANK_GATE_EN to hold each write until VBLANK is high.
module pal_dma_writer #(
    parameter int          SRC_AW     = 20,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int          ENTRIES    = 256
) (
    input  logic              CLK_32M,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [SRC_AW-1:0] SRC_BASE,
    output logic              BUSY,
    output logic              DONE,
    output logic [SRC_AW-1:0] SRC_ADDR,
    output logic              SRC_RD,
    input  logic              SRC_ACK,
    input  logic [15:0]       SRC_DATA,
    output logic              PAL_G,
    output logic              PAL_MWR,
    output logic [19:0]       PAL_A,
    output logic [15:0]       PAL_DIN,
    input  logic              VBLANK
);
    import pal_dma_pkg::*;

    pal_dma_state_t r_state, w_next;
    // Set once the word for the current entry is captured; FETCH then idles one
    // cycle with SRC_RD low so PAL_DIN is stable for a full cycle before WRITE.
    logic           r_have;
    logic [15:0]    r_din;
    logic [15:0]    r_gap_cnt;

    logic w_load, w_capture, w_advance, w_last, w_gap_done, w_vblank_ok;
    logic w_unused;

`ifdef PAL_DMA_VBLANK_GATE_EN
    assign w_vblank_ok = VBLANK;
    assign w_unused    = &{1'b0, SRC_DATA[15:5]};
`else
    assign w_vblank_ok = 1'b1;
    assign w_unused    = &{1'b0, SRC_DATA[15:5], VBLANK};
`endif

    assign w_gap_done = (32'(r_gap_cnt) + 32'd1 >= GAP_CYCLES);

    pal_dma_addr_gen #(
        .SRC_AW  (SRC_AW),
        .ENTRIES (ENTRIES)
    ) u_addr_gen (
        .i_clk      (CLK_32M),
        .i_rst_n    (RESET_N),
        .i_load     (w_load),
        .i_base     (SRC_BASE),
        .i_advance  (w_advance),
        .o_src_addr (SRC_ADDR),
        .o_pal_a    (PAL_A),
        .o_last     (w_last)
    );

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_have    <= 1'b0;
            r_din     <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_have <= 1'b1;
                r_din  <= {11'd0, SRC_DATA[4:0]};
            end else if (w_load || r_state == ST_WRITE) begin
                r_have <= 1'b0;
            end
            if (r_state == ST_WRITE) begin
                r_gap_cnt <= '0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_load = 1'b1;
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!r_have) begin
                    w_capture = SRC_ACK;
                end else if (w_vblank_ok) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (GAP_CYCLES != 0) begin
                    w_next = ST_GAP;
                end else if (w_last) begin
                    w_next = ST_FINISH;
                end else begin
                    w_advance = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    if (w_last) begin
                        w_next = ST_FINISH;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = ST_FETCH;
                    end
                end
            end
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign BUSY    = (r_state == ST_FETCH) || (r_state == ST_WRITE) || (r_state == ST_GAP);
    assign DONE    = (r_state == ST_FINISH);
    assign SRC_RD  = (r_state == ST_FETCH) && !r_have;
    assign PAL_G   = (r_state == ST_WRITE);
    assign PAL_MWR = (r_state == ST_WRITE);
    assign PAL_DIN = r_din;

endmodule

// File: tb/tb_pal_dma_writer.sv
module tb_pal_dma_writer;

    logic        CLK_32M = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [19:0] SRC_BASE = '0;
    logic        SRC_ACK = 1'b0;
    logic [15:0] SRC_DATA = '0;
    logic        VBLANK = 1'b1;
    logic        BUSY, DONE, SRC_RD, PAL_G, PAL_MWR;
    logic [19:0] SRC_ADDR, PAL_A;
    logic [15:0] PAL_DIN;

    always #5 CLK_32M = ~CLK_32M;

    pal_dma_writer #(.SRC_AW(20), .GAP_CYCLES(1), .ENTRIES(256)) dut (
        .CLK_32M (CLK_32M), .RESET_N (RESET_N), .START (START), .SRC_BASE (SRC_BASE),
        .BUSY (BUSY), .DONE (DONE), .SRC_ADDR (SRC_ADDR), .SRC_RD (SRC_RD),
        .SRC_ACK (SRC_ACK), .SRC_DATA (SRC_DATA), .PAL_G (PAL_G), .PAL_MWR (PAL_MWR),
        .PAL_A (PAL_A), .PAL_DIN (PAL_DIN), .VBLANK (VBLANK)
    );

    int checks = 0;
    int failures = 0;

    logic [35:0] exp_pal_q[$];
    logic [19:0] exp_src_q[$];
    int          src_mode = 0;
    int          ack_delay = 0;
    bit          rand_ack = 1'b0;
    int          wr_count = 0;
    int          fetch_count = 0;
    int          done_cnt = 0;
    logic [19:0] wr_addr_log[0:767];
    logic [19:0] src_log[0:767];
    logic [15:0] pal_ram[0:1023];

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source image; mode 1 puts junk in bits [15:5] that must not reach PAL_DIN.
    function automatic logic [15:0] src_word(input logic [19:0] a);
        if (src_mode == 0) return {11'd0, a[4:0]};
        return 16'hF800 ^ {a[19:9], a[4:0] ^ a[9:5]};
    endfunction

    task automatic push_expected(input logic [19:0] base);
        logic [19:0] src;
        logic [15:0] w;
        logic [9:0]  nv;
        for (int n = 0; n < 768; n++) begin
            nv  = 10'(n);
            src = base + 20'(n);
            w   = src_word(src);
            exp_src_q.push_back(src);
            exp_pal_q.push_back({8'd0, nv[9:8], 1'b0, nv[7:0], 1'b0, 11'd0, w[4:0]});
        end
    endtask

    // Work-RAM responder: ack after ack_delay cycles of SRC_RD, junk data otherwise.
    int          wcnt = 0;
    bit          rd_seen = 1'b0;
    logic [19:0] rd_addr = '0;
    always @(posedge CLK_32M) begin
        #1;
        SRC_ACK  = 1'b0;
        SRC_DATA = 16'($urandom);
        if (RESET_N && SRC_RD) begin
            if (!rd_seen) begin
                rd_seen = 1'b1;
                rd_addr = SRC_ADDR;
                if (fetch_count < 768) src_log[fetch_count] = SRC_ADDR;
                fetch_count++;
                if (exp_src_q.size() == 0) check("src_unexpected", 36'(SRC_ADDR), 36'hFFFFFFFFF);
                else check("src_addr", 36'(SRC_ADDR), 36'(exp_src_q.pop_front()));
            end else begin
                check("src_addr_stable", 36'(SRC_ADDR), 36'(rd_addr));
            end
            if (wcnt >= ack_delay) begin
                SRC_ACK  = 1'b1;
                SRC_DATA = src_word(SRC_ADDR);
                wcnt     = 0;
                rd_seen  = 1'b0;
                if (rand_ack) ack_delay = $urandom_range(0, 7);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt    = 0;
            rd_seen = 1'b0;
            if (rand_ack && $urandom_range(0, 3) == 0) SRC_ACK = 1'b1;
        end
    end

    // Palette chip model and write scoreboard.
    logic [35:0] prev_ad = '0;
    logic        prev_mwr = 1'b0;
    always @(posedge CLK_32M) begin
        #1;
        if (PAL_MWR || PAL_G) begin
            check("strobe_pair", 36'(PAL_G), 36'(PAL_MWR));
            check("strobe_single", 36'(prev_mwr), 36'd0);
            check("pal_stable", {PAL_A, PAL_DIN}, prev_ad);
            if (exp_pal_q.size() == 0) check("pal_unexpected", {PAL_A, PAL_DIN}, 36'hFFFFFFFFF);
            else check("pal_write", {PAL_A, PAL_DIN}, exp_pal_q.pop_front());
            if (wr_count < 768) wr_addr_log[wr_count] = PAL_A;
            pal_ram[{PAL_A[11:10], PAL_A[8:1]}] = PAL_DIN;
            wr_count++;
        end
        if (DONE) begin
            done_cnt++;
            check("done_busy_low", 36'(BUSY), 36'd0);
        end
        prev_ad  = {PAL_A, PAL_DIN};
        prev_mwr = PAL_MWR;
    end

    task automatic do_start(input logic [19:0] base, input bit expect_it);
        if (expect_it) begin
            exp_src_q.delete();
            exp_pal_q.delete();
            push_expected(base);
            wr_count    = 0;
            fetch_count = 0;
            for (int k = 0; k < 1024; k++) pal_ram[k] = 16'hDEAD;
        end
        SRC_BASE = base;
        START    = 1'b1;
        @(posedge CLK_32M);
        #2;
        START = 1'b0;
    endtask

    // Cycles counted from the edge that accepted START to the edge raising DONE.
    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge CLK_32M);
            #2;
            if (DONE) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) check("done_timeout", 36'(DONE), 36'd1);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge CLK_32M);
            #2;
            if (wr_count >= n) return;
        end
        check("write_wait_timeout", 36'(wr_count), 36'(n));
    endtask

    task automatic check_ram(input logic [19:0] base, input string tag);
        int bad;
        logic [15:0] w;
        bad = 0;
        for (int n = 0; n < 768; n++) begin
            w = src_word(base + 20'(n));
            if (pal_ram[n] !== {11'd0, w[4:0]}) bad++;
        end
        check(tag, 36'(bad), 36'd0);
        check({tag, "_pal_q"}, 36'(exp_pal_q.size()), 36'd0);
        check({tag, "_src_q"}, 36'(exp_src_q.size()), 36'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 36'(BUSY), 36'd0);
        check({tag, "_done"}, 36'(DONE), 36'd0);
        check({tag, "_src_addr"}, 36'(SRC_ADDR), 36'd0);
        check({tag, "_src_rd"}, 36'(SRC_RD), 36'd0);
        check({tag, "_pal_g"}, 36'(PAL_G), 36'd0);
        check({tag, "_pal_mwr"}, 36'(PAL_MWR), 36'd0);
        check({tag, "_pal_a"}, 36'(PAL_A), 36'd0);
        check({tag, "_pal_din"}, 36'(PAL_DIN), 36'd0);
    endtask

    initial begin
        int cyc;
        int d0;

        // Reset state.
        repeat (3) @(posedge CLK_32M);
        #2;
        check_idle_outputs("reset");
        @(negedge CLK_32M);
        RESET_N = 1'b1;
        @(posedge CLK_32M);
        #2;

        // Basic upload, zero-wait ack.
        src_mode = 0; rand_ack = 1'b0; ack_delay = 0;
        d0 = done_cnt;
        do_start(20'h01000, 1'b1);
        check("basic_busy", 36'(BUSY), 36'd1);
        wait_done(4000, cyc);
        check("basic_done_latency", 36'(cyc), 36'd3072);
        repeat (3) @(posedge CLK_32M);
        #2;
        check("basic_busy_after", 36'(BUSY), 36'd0);
        check("basic_done_once", 36'(done_cnt - d0), 36'd1);
        check("basic_writes", 36'(wr_count), 36'd768);
        check("basic_first_a", 36'(wr_addr_log[0]), 36'h00000);
        check("basic_257_a", 36'(wr_addr_log[256]), 36'h00400);
        check("basic_513_a", 36'(wr_addr_log[512]), 36'h00800);
        check("basic_last_a", 36'(wr_addr_log[767]), 36'h009FE);
        check_ram(20'h01000, "basic_ram");

        // Random ack latency with junk acks while not fetching.
        src_mode = 1; rand_ack = 1'b1; ack_delay = 3;
        do_start(20'h2A5C3, 1'b1);
        wait_done(768 * 16, cyc);
        repeat (3) @(posedge CLK_32M);
        #2;
        check("lat_writes", 36'(wr_count), 36'd768);
        check_ram(20'h2A5C3, "lat_ram");

        // Source address wrap; without the gate option VBLANK must not matter.
        src_mode = 0; rand_ack = 1'b0; ack_delay = 0;
`ifndef PAL_DMA_VBLANK_GATE_EN
        VBLANK = 1'b0;
`endif
        @(posedge CLK_32M);
        #2;
        do_start(20'hFFF80, 1'b1);
        wait_done(4000, cyc);
        check("wrap_done_latency", 36'(cyc), 36'd3072);
        VBLANK = 1'b1;
        check("wrap_r127_src", 36'(src_log[127]), 36'hFFFFF);
        check("wrap_r128_src", 36'(src_log[128]), 36'h00000);
        repeat (2) @(posedge CLK_32M);
        #2;
        check_ram(20'hFFF80, "wrap_ram");

        // START while busy is ignored.
        d0 = done_cnt;
        do_start(20'h00300, 1'b1);
        wait_writes(100, 1000);
        do_start(20'h55555, 1'b0);
        check("busy_start_busy", 36'(BUSY), 36'd1);
        wait_done(4000, cyc);
        repeat (5) @(posedge CLK_32M);
        #2;
        check("busy_start_done_once", 36'(done_cnt - d0), 36'd1);
        check("busy_start_last_src", 36'(src_log[767]), 36'h005FF);
        check_ram(20'h00300, "busy_start_ram");

        // Reset mid-upload, then restart from R entry 0.
        d0 = done_cnt;
        do_start(20'h10000, 1'b1);
        wait_writes(400, 4000);
        RESET_N = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (20) @(posedge CLK_32M);
        #2;
        check("midreset_no_done", 36'(done_cnt - d0), 36'd0);
        @(negedge CLK_32M);
        RESET_N = 1'b1;
        @(posedge CLK_32M);
        #2;
        do_start(20'h20000, 1'b1);
        wait_done(4000, cyc);
        check("restart_done_latency", 36'(cyc), 36'd3072);
        check("restart_first_src", 36'(src_log[0]), 36'h20000);
        check("restart_first_a", 36'(wr_addr_log[0]), 36'h00000);
        repeat (2) @(posedge CLK_32M);
        #2;
        check_ram(20'h20000, "restart_ram");

`ifdef PAL_DMA_VBLANK_GATE_EN
        // Writes stall while VBLANK is low and resume on the edge that samples it high.
        do_start(20'h00000, 1'b1);
        wait_writes(10, 200);
        VBLANK = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge CLK_32M);
            #2;
            check("vblank_no_strobe", 36'(PAL_MWR), 36'd0);
        end
        check("vblank_writes_held", 36'(wr_count), 36'd10);
        VBLANK = 1'b1;
        @(posedge CLK_32M);
        #2;
        check("vblank_resume_strobe", 36'(PAL_MWR), 36'd1);
        check("vblank_resume_count", 36'(wr_count), 36'd11);
        wait_done(4000, cyc);
        repeat (2) @(posedge CLK_32M);
        #2;
        check_ram(20'h00000, "vblank_ram");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pal_dma_writer.md
Name: pal_dma_writer

Overview:
- Bus initiator that bulk-uploads a full palette (R, G, B planes, 256 entries each) into the M72 palette chip through its CPU-side write interface (G, MWR, A, DIN).
- Fetches source words from a work-RAM port with a req/ack handshake, then issues one palette write strobe per word.
- Sits between the sprite/palette buffer RAM and the palette chip; replaces CPU-driven palette writes during frame setup.

Parameters:
- SRC_AW, 20, source word-address width.
- GAP_CYCLES, 1, idle CLK_32M cycles inserted after each palette write strobe (0 allowed).
- ENTRIES, 256, entries per colour plane (fixed to 256 by the A[8:1] field; other values unsupported).

Ports:
- CLK_32M  in  1  system clock, all logic on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins an upload when idle.
- SRC_BASE  in  SRC_AW  source word address of R entry 0; sampled on accepted START.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse after the 768th write.
- SRC_ADDR  out  SRC_AW  source word address.
- SRC_RD  out  1  read request, held until SRC_ACK.
- SRC_ACK  in  1  source data valid this cycle.
- SRC_DATA  in  16  source word; bits [4:0] are the colour value.
- PAL_G  out  1  palette chip select (G).
- PAL_MWR  out  1  palette write strobe.
- PAL_A  out  20  palette address.
- PAL_DIN  out  16  palette write data.
- VBLANK  in  1  vertical blank; used only with the optional feature.

Behaviour:
- Reset: every output is 0. State is IDLE. Counters are 0. Reset mid-upload aborts immediately with no DONE pulse.
- Upload order: plane c = 0 (R), 1 (G), 2 (B); within each plane, entry i = 0..255.
- Source address: SRC_ADDR = SRC_BASE + c*256 + i, computed modulo 2^SRC_AW (wraps).
- Palette address: PAL_A = {8'd0, A11:A10, 1'b0, i[7:0], 1'b0}.
  - A11:A10 = 00 for R, 01 for G, 10 for B.
  - A[0] = 0 always; A[9] = 0.
- PAL_DIN = {11'd0, SRC_DATA[4:0]}, registered on SRC_ACK.
- FSM states: IDLE, FETCH, WRITE, GAP, FINISH.
  - IDLE: START latches SRC_BASE, sets BUSY, goes to FETCH next cycle.
  - FETCH: SRC_RD = 1 with a stable SRC_ADDR. On SRC_ACK, capture data, drop SRC_RD, go to WRITE. SRC_ACK in the same cycle SRC_RD first rises is legal.
  - WRITE: exactly one cycle with PAL_G = PAL_MWR = 1. PAL_A and PAL_DIN are stable from the preceding cycle through this cycle.
  - After WRITE: go to GAP if GAP_CYCLES > 0, else continue directly.
  - GAP: PAL_G and PAL_MWR low for GAP_CYCLES cycles.
  - Continue: advance {c, i}. Return to FETCH, or go to FINISH after c = 2, i = 255.
  - FINISH: DONE = 1 for one cycle, BUSY = 0 in the same cycle, then IDLE.
- Throughput with zero-wait ack: one write per (3 + GAP_CYCLES) cycles.
- START while BUSY is ignored and does not re-sample SRC_BASE. START in the FINISH cycle is ignored.
- SRC_ACK outside FETCH is ignored.
- PAL_G and PAL_MWR are never high outside WRITE. This block never asserts a palette read.

Optional Feature:
- Macro: PAL_DMA_VBLANK_GATE_EN.
- Defined: the FETCH-to-WRITE transition stalls while VBLANK = 0.
  - Captured data is held and the PAL_* strobes stay low.
  - WRITE is issued on the first cycle with VBLANK = 1.
  - A strobe already in WRITE always completes.
- Undefined: VBLANK is ignored (port kept, unused).

Decomposition:
- Shared package pal_dma_pkg holds:
  - FSM state enum.
  - Plane-select constants PLANE_R = 2'b00, PLANE_G = 2'b01, PLANE_B = 2'b10.
  - PAL_ENTRIES = 256 and PAL_WRITES = 768.
- Natural sub-module: pal_dma_addr_gen, holding the {c, i} counter and the SRC_ADDR/PAL_A formation plus a last-entry flag. The FSM stays in the top level.

Test Plan:
- Basic upload: SRC_BASE = 0x01000, GAP_CYCLES = 1, SRC_ACK returned the cycle after SRC_RD, source word n = n[4:0] -> 768 strobes; first PAL_A = 0x00000, write 257 PAL_A = 0x00400, write 513 PAL_A = 0x00800, last PAL_A = 0x009FE; DONE once, 3072 cycles after START, BUSY low afterwards.
- Ack latency: random 0..7 cycle SRC_ACK delay -> SRC_ADDR stable while SRC_RD is high; the palette chip model's RAM matches the source image exactly.
- Wrap: SRC_BASE = 0xFFF80 -> R entry 128 reads SRC_ADDR 0x00000.
- Busy START: second START at write 100 with a new SRC_BASE -> ignored; addresses continue from the original base; a single DONE.
- Reset mid-upload: RESET_N low at write 400 -> all outputs 0 immediately, no DONE; a subsequent START restarts from R entry 0.
- With PAL_DMA_VBLANK_GATE_EN: VBLANK low for 50 cycles at write 10 -> no PAL_MWR during that window; write 10 issues on the first cycle VBLANK is high; final RAM contents correct.
